// File: rtl/router_pkg.sv
// Shared FSM state encoding and header decode for the 1-to-N packet router.
package router_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t WAIT  = 3'd1;
  localparam state_t LOAD  = 3'd2;
  localparam state_t CHECK = 3'd3;
  localparam state_t DROP  = 3'd4;

  // Port address lives in the low addr_w bits of the header (addr_w <= 4).
  function automatic logic [3:0] hdr_addr(input logic [3:0] hdr_lo, input int unsigned addr_w);
    logic [3:0] mask;
    mask = 4'((32'd1 << addr_w) - 32'd1);
    return hdr_lo & mask;
  endfunction

endpackage

// File: rtl/router_fifo_n.sv
// Per-port synchronous FIFO with registered read data and a flush used for timeout recovery.
module router_fifo_n #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enb,
  input  logic              flush,
  input  logic              read_enb,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              do_wr, do_rd;

  // Extra wrap bit tells full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_wr = write_enb && !full && !flush;
  assign do_rd = read_enb && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_out <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_out <= mem[rd_ptr_q[PTR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr_q[PTR_W-1:0]] <= data_in;
  end

endmodule

// File: rtl/router_1xn_top.sv
// 1-to-N packet router: header steering, parity check, back-pressure and per-port timeout flush.
// Optional ROUTER_DROP_CNT_EN adds a saturating drop_count output.
module router_1xn_top
  import router_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 30
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pkt_valid,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          busy,
  output logic                          error,
  input  logic [NUM_PORTS-1:0]          read_enb,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          valid_out,
  output logic [NUM_PORTS-1:0]          soft_reset
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_count
`endif
);

  localparam int unsigned ADDR_W = (NUM_PORTS <= 2) ? 1 : $clog2(NUM_PORTS);
  localparam int unsigned PAD    = 1 << ADDR_W;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, hdr_a;
  logic [DATA_W-1:0]     parity_q, parity_d;
  logic                  error_q, error_d;
  logic [NUM_PORTS-1:0]  full, empty, flush, wr_port;
  logic [PAD-1:0]        full_pad, flush_pad;
  logic                  hdr_ok, wr_en, drop_enter;

  assign hdr_a  = ADDR_W'(hdr_addr(data_in[3:0], ADDR_W));
  assign hdr_ok = (32'(hdr_a) < NUM_PORTS);

  // Padded views so any address value indexes safely.
  always_comb begin
    full_pad                   = '0;
    flush_pad                  = '0;
    full_pad[NUM_PORTS-1:0]    = full;
    flush_pad[NUM_PORTS-1:0]   = flush;
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      WAIT:    busy = 1'b1;
      LOAD:    busy = full_pad[addr_q];
      CHECK:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    parity_d   = parity_q;
    error_d    = error_q;
    wr_en      = 1'b0;
    drop_enter = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          error_d = 1'b0;
          addr_d  = hdr_a;
          if (!hdr_ok || flush_pad[hdr_a]) begin
            state_d    = DROP;
            drop_enter = 1'b1;
          end else if (full_pad[hdr_a]) begin
            state_d = WAIT;
          end else begin
            wr_en    = 1'b1;
            parity_d = data_in;
            state_d  = LOAD;
          end
        end
      end
      WAIT: begin
        if (flush_pad[addr_q]) begin
          state_d    = DROP;
          drop_enter = 1'b1;
        end else if (!full_pad[addr_q]) begin
          wr_en    = 1'b1;
          parity_d = data_in;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (flush_pad[addr_q]) begin
          // A parity byte accepted on the flush edge ends the packet outright.
          if (!full_pad[addr_q] && !pkt_valid) begin
            state_d = IDLE;
          end else begin
            state_d    = DROP;
            drop_enter = 1'b1;
          end
        end else if (!full_pad[addr_q]) begin
          wr_en    = 1'b1;
          parity_d = parity_q ^ data_in;
          if (!pkt_valid) state_d = CHECK;
        end
      end
      CHECK: begin
        // Parity byte was folded in, so a clean packet leaves zero.
        error_d = |parity_q;
        state_d = IDLE;
      end
      DROP: begin
        if (!pkt_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      parity_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      parity_q <= parity_d;
      error_q  <= error_d;
    end
  end

  assign error      = error_q;
  assign valid_out  = ~empty;
  assign soft_reset = flush;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [CNT_W-1:0] cnt_q;

    assign wr_port[i] = wr_en && (32'(addr_d) == i);
    assign flush[i]   = (cnt_q == CNT_W'(TIMEOUT - 1)) && !empty[i] && !read_enb[i];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (flush[i] || read_enb[i] || empty[i]) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    router_fifo_n #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .write_enb (wr_port[i]),
      .flush     (flush[i]),
      .read_enb  (read_enb[i]),
      .data_in   (data_in),
      .data_out  (data_out[i*DATA_W +: DATA_W]),
      .empty     (empty[i]),
      .full      (full[i])
    );
  end

`ifdef ROUTER_DROP_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_enter && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  logic unused_drop_enter;
  assign unused_drop_enter = drop_enter;
`endif

endmodule

// File: tb/tb_router_1xn_top.sv
// Directed self-checking bench for router_1xn_top (NUM_PORTS=3, FIFO_DEPTH=8, TIMEOUT=30).
module tb_router_1xn_top;

  logic        clock = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic        busy;
  logic        error;
  logic [2:0]  read_enb;
  logic [23:0] data_out;
  logic [2:0]  valid_out;
  logic [2:0]  soft_reset;
`ifdef ROUTER_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  router_1xn_top #(
    .DATA_W     (8),
    .NUM_PORTS  (3),
    .FIFO_DEPTH (8),
    .TIMEOUT    (30)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .busy       (busy),
    .error      (error),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .soft_reset (soft_reset)
`ifdef ROUTER_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one byte; busy must be low before the accepting edge.
  task automatic send(input logic v, input logic [7:0] d);
    int guard;
    pkt_valid = v;
    data_in   = d;
    #1;
    guard = 0;
    while (busy === 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk("send_busy", {31'd0, busy}, 32'd0);
    tick();
  endtask

  logic [7:0] exp_b [12];
  logic [7:0] p1 [5];

  initial begin
    int rd;
    int guard;

    reset     = 1'b1;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    read_enb  = 3'b000;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_valid", {29'd0, valid_out}, 32'd0);
    chk("rst_soft", {29'd0, soft_reset}, 32'd0);
    chk("rst_dout", {8'd0, data_out}, 32'd0);
`ifdef ROUTER_DROP_CNT_EN
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Good packet to port 1: 0D 11 22 33, parity 0D.
    send(1'b1, 8'h0D);
    chk("p1_valid_next", {29'd0, valid_out}, 32'b010);
    send(1'b1, 8'h11);
    send(1'b1, 8'h22);
    send(1'b1, 8'h33);
    pkt_valid = 1'b0;
    data_in   = 8'h0D;
    tick();
    chk("p1_check_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("p1_error", {31'd0, error}, 32'd0);
    chk("p1_idle_busy", {31'd0, busy}, 32'd0);
    p1[0] = 8'h0D; p1[1] = 8'h11; p1[2] = 8'h22; p1[3] = 8'h33; p1[4] = 8'h0D;
    read_enb = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("p1_rd%0d", i), {24'd0, data_out[15:8]}, {24'd0, p1[i]});
    end
    chk("p1_drained", {29'd0, valid_out}, 32'd0);
    tick();
    chk("p1_rd_empty_hold", {24'd0, data_out[15:8]}, 32'h0D);
    read_enb = 3'b000;

    // Bad parity to port 0: 04 AA, parity sent AF (correct AE).
    send(1'b1, 8'h04);
    send(1'b1, 8'hAA);
    send(1'b0, 8'hAF);
    tick();
    chk("bad_par_error", {31'd0, error}, 32'd1);
    read_enb = 3'b001;
    tick();
    chk("p0_rd0", {24'd0, data_out[7:0]}, 32'h04);
    tick();
    chk("p0_rd1", {24'd0, data_out[7:0]}, 32'hAA);
    tick();
    chk("p0_rd2", {24'd0, data_out[7:0]}, 32'hAF);
    read_enb = 3'b000;
    chk("err_held", {31'd0, error}, 32'd1);

    // Next header (port 2) clears error on acceptance; then left unread to time out.
    send(1'b1, 8'h02);
    chk("err_cleared", {31'd0, error}, 32'd0);
    send(1'b1, 8'h55);
    send(1'b0, 8'h57);
    tick();
    chk("p2_error", {31'd0, error}, 32'd0);
    repeat (25) tick();
    chk("to_pre_soft", {29'd0, soft_reset}, 32'd0);
    chk("to_pre_valid", {29'd0, valid_out}, 32'b100);
    tick();
    chk("to_soft_pulse", {29'd0, soft_reset}, 32'b100);
    tick();
    chk("to_soft_done", {29'd0, soft_reset}, 32'd0);
    chk("to_flushed", {29'd0, valid_out}, 32'd0);

    // Address 3 does not exist: whole packet discarded without back-pressure.
    send(1'b1, 8'h03);
    send(1'b1, 8'h44);
    send(1'b1, 8'h55);
    send(1'b0, 8'h12);
    chk("drop_no_write", {29'd0, valid_out}, 32'd0);
`ifdef ROUTER_DROP_CNT_EN
    chk("drop_count", {16'd0, drop_count}, 32'd1);
`endif

    // Overflow port 0 (depth 8): 28, 01..0A, parity 23.
    exp_b[0] = 8'h28;
    for (int i = 1; i <= 10; i++) exp_b[i] = 8'(i);
    exp_b[11] = 8'h23;
    for (int i = 0; i < 8; i++) send(1'b1, exp_b[i]);
    pkt_valid = 1'b1;
    data_in   = exp_b[8];
    #1;
    chk("ovf_busy", {31'd0, busy}, 32'd1);
    rd = 0;
    for (int j = 8; j < 12; j++) begin
      pkt_valid = (j != 11);
      data_in   = exp_b[j];
      #1;
      guard = 0;
      while (busy === 1'b1 && guard < 10) begin
        read_enb = 3'b001;
        tick();
        read_enb = 3'b000;
        chk($sformatf("ovf_rd%0d", rd), {24'd0, data_out[7:0]}, {24'd0, exp_b[rd]});
        rd++;
        guard++;
      end
      chk("ovf_release", {31'd0, busy}, 32'd0);
      tick();
    end
    pkt_valid = 1'b0;
    tick();
    chk("ovf_error", {31'd0, error}, 32'd0);
    read_enb = 3'b001;
    guard = 0;
    while (rd < 12 && guard < 20) begin
      tick();
      chk($sformatf("ovf_rd%0d", rd), {24'd0, data_out[7:0]}, {24'd0, exp_b[rd]});
      rd++;
      guard++;
    end
    read_enb = 3'b000;
    chk("ovf_count", rd, 32'd12);
    chk("ovf_drained", {29'd0, valid_out}, 32'd0);

    // Reset mid-payload, then a full packet 05 99 9C to port 1.
    send(1'b1, 8'h01);
    send(1'b1, 8'h77);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {29'd0, valid_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_dout", {8'd0, data_out}, 32'd0);
    chk("mid_rst_error", {31'd0, error}, 32'd0);
    pkt_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    send(1'b1, 8'h05);
    send(1'b1, 8'h99);
    send(1'b0, 8'h9C);
    tick();
    chk("post_rst_error", {31'd0, error}, 32'd0);
    chk("post_rst_valid", {29'd0, valid_out}, 32'b010);
    read_enb = 3'b010;
    tick();
    chk("post_rd0", {24'd0, data_out[15:8]}, 32'h05);
    tick();
    chk("post_rd1", {24'd0, data_out[15:8]}, 32'h99);
    tick();
    chk("post_rd2", {24'd0, data_out[15:8]}, 32'h9C);
    read_enb = 3'b000;
    tick();
    chk("post_drained", {29'd0, valid_out}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_1xn_top.md
Name: router_1xn_top

Overview:
Parametrised 1-to-N packet router. It is the next generation of the fixed 1x3, 8-bit router. A single input byte stream carries header, payload and parity. The block steers each packet into one of NUM_PORTS per-port FIFOs, checks parity and back-pressures the sender. Each port's FIFO is flushed when that port's consumer stalls. Unlike the 1x3 block, it drops packets addressed to non-existent ports instead of misrouting them.

Parameters:
DATA_W, 8, byte width of data_in/data_out
NUM_PORTS, 3, number of output ports (2..16); ADDR_W = max(1, $clog2(NUM_PORTS)) is a localparam
FIFO_DEPTH, 16, entries per port FIFO; power of 2, >= 4
TIMEOUT, 30, consecutive unread cycles with valid_out high before a port is soft-reset

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
pkt_valid  in  1  high for header and payload bytes, low on the parity byte
data_in  in  DATA_W  packet byte
busy  out  1  sender must hold data_in/pkt_valid while high
error  out  1  parity mismatch on the last completed packet
read_enb  in  NUM_PORTS  per-port read request
data_out  out  NUM_PORTS*DATA_W  port i occupies bits [i*DATA_W +: DATA_W]
valid_out  out  NUM_PORTS  port FIFO non-empty
soft_reset  out  NUM_PORTS  one-cycle pulse when port i is flushed by timeout

Behaviour:
- Reset: busy=0, error=0, valid_out=0, soft_reset=0, data_out=0, FSM=IDLE, all FIFOs empty, timeout counters 0.
- Packet format:
  - header: addr = data_in[ADDR_W-1:0]; remaining bits are payload length (informational only, not checked).
  - payload: bytes follow the header.
  - parity: one byte, XOR of header and all payload bytes.
- A byte is accepted on any rising edge where busy=0 and either (state=IDLE and pkt_valid=1) or state=LOAD.
- FSM states:
  - IDLE: pkt_valid=1 samples header and clears error.
    - addr>=NUM_PORTS -> DROP.
    - target FIFO full -> WAIT; busy=1, header not consumed.
    - else header written to FIFO[addr], running parity = header -> LOAD.
  - WAIT: busy=1. Header is written the first cycle FIFO[addr] is not full -> LOAD.
  - LOAD: each accepted byte is written to FIFO[addr] and XORed into running parity.
    - If FIFO[addr] is full, busy=1 (combinational from full) and no write occurs.
    - First accepted byte with pkt_valid=0 is the parity byte; it is written like data -> CHECK.
  - CHECK: busy=1 for exactly one cycle; error <= (running parity != parity byte) -> IDLE.
  - DROP: bytes consumed and discarded, busy=0, nothing written. First byte with pkt_valid=0 -> IDLE. error unchanged.
- Latency: a header accepted in cycle n gives valid_out[addr]=1 in cycle n+1.
- FIFO read:
  - read_enb[i]=1 with FIFO i non-empty updates data_out[i] on that edge (registered, 1-cycle latency).
  - Read while empty is ignored; data_out holds its last value.
  - Simultaneous read and write on the same FIFO is legal. Write permission uses full as sampled in that cycle, so a full FIFO with a concurrent read still blocks the write.
- Pointers: FIFO_DEPTH-wrap, with an extra wrap bit for full/empty detection. valid_out[i] = ~empty[i].
- Timeout:
  - Per-port counter increments while valid_out[i]=1 and read_enb[i]=0.
  - Counter clears on read_enb[i]=1 or when FIFO i is empty.
  - At count==TIMEOUT-1 the next edge empties FIFO i, pulses soft_reset[i] and clears the counter.
  - If the FSM is in LOAD/WAIT/CHECK for port i at that edge: LOAD/WAIT go to DROP, so the remaining bytes are discarded; CHECK completes normally.
- Reset asserted mid-packet aborts the packet immediately. The sender must restart with a header.

Optional Feature:
ROUTER_DROP_CNT_EN:
- With the macro defined, adds output drop_count [15:0], reset 0. It increments, saturating at 16'hFFFF, once per packet entering DROP, whether from a bad address or a timeout.
- Without it, the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package router_pkg: FSM state enum (IDLE, WAIT, LOAD, CHECK, DROP) and the addr-extract function.
- One sub-module router_fifo_n (params DATA_W, FIFO_DEPTH; ports clock, reset, write_enb, flush, read_enb, data_in, data_out, empty, full), instantiated NUM_PORTS times in a generate loop.
- FSM, parity and timeout logic stay in the top.

Test Plan:
- NUM_PORTS=3: header 8'h0D (addr 1, len 3), payload 11,22,33, correct parity -> port 1 holds 5 bytes, valid_out=3'b010 next cycle, error=0.
- Wrong parity byte (correct value XOR 8'h01) -> error=1 the cycle after CHECK; error clears when the next header is accepted.
- NUM_PORTS=3, header addr=3 -> no FIFO write, busy stays 0, all bytes discarded; with ROUTER_DROP_CNT_EN, drop_count=1.
- FIFO_DEPTH=4, 6-byte payload to port 0, no reads -> busy=1 once 4 entries are stored; asserting read_enb[0] releases busy and all 8 bytes arrive in order.
- Port 2 loaded, read_enb[2]=0 for TIMEOUT cycles -> soft_reset[2] pulse at cycle TIMEOUT, valid_out[2]=0 next cycle, other ports unaffected.
- reset pulsed mid-payload -> all outputs return to reset values asynchronously; a following full packet routes correctly.
